layer1_fetch_ctrl: RTL and testbench

LAYER1_FETCH_CTRL -- requirements
Module: layer1_fetch_ctrl

---
 rtl/layer1_pkg.sv | 15 +
 rtl/layer1_skid_fifo.sv | 46 ++++
 rtl/layer1_fetch_ctrl.sv | 104 ++++++++++
 tb/tb_layer1_fetch_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/layer1_pkg.sv
// Shared defaults and FSM encoding for the layer-1 BRAM fetch controller.
package layer1_pkg;

    localparam int unsigned N_BRAM1_DEF    = 3;
    localparam int unsigned DATA_WIDTH_DEF = 16;
    localparam int unsigned ADDR_WIDTH_DEF = 10;
    localparam int unsigned N_WORDS_DEF    = 1024;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/layer1_skid_fifo.sv
// Two-entry FIFO holding fetched words and their last-word flag; push and pop may coincide.
module layer1_skid_fifo #(
    parameter int unsigned WIDTH = 48
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             push_last,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             head_last,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem_data [2];
    logic [1:0]       mem_last;
    logic             wr_ptr;
    logic             rd_ptr;

    // When full, wr_ptr aliases rd_ptr, so a simultaneous push overwrites the slot being popped.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_data[0] <= '0;
            mem_data[1] <= '0;
            mem_last    <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= 2'd0;
        end else begin
            if (push) begin
                mem_data[wr_ptr] <= push_data;
                mem_last[wr_ptr] <= push_last;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end

    assign head_data = mem_data[rd_ptr];
    assign head_last = mem_last[rd_ptr];

endmodule

// File: rtl/layer1_fetch_ctrl.sv
// Streams N_WORDS consecutive words out of the layer-1 BRAM bank to the conv stage
// with a valid/ready handshake, keeping at most two words buffered or in flight.
module layer1_fetch_ctrl
    import layer1_pkg::*;
#(
    parameter int unsigned N_BRAM1    = N_BRAM1_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned N_WORDS    = N_WORDS_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    output logic [ADDR_WIDTH-1:0]         BRAM1_addr,
    input  logic [N_BRAM1*DATA_WIDTH-1:0] BRAM_out,
    output logic [N_BRAM1*DATA_WIDTH-1:0] out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_last,
    output logic                          busy,
    output logic                          done
);

    localparam int unsigned            BUS_W     = N_BRAM1 * DATA_WIDTH;
    localparam logic [ADDR_WIDTH-1:0]  LAST_ADDR = ADDR_WIDTH'(N_WORDS - 1);

    fetch_state_t          state;
    logic [ADDR_WIDTH-1:0] counter;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  inflight;
    logic                  inflight_last;
    logic [1:0]            fifo_count;
    logic                  pop;
    logic                  issue;
    logic                  issue_last;
    logic                  final_hs;

    assign out_valid  = (fifo_count != 2'd0);
    assign pop        = out_valid && out_ready;
    // Credit: buffered plus in-flight never exceeds two; a pop frees a slot this same cycle.
    assign issue      = (state == S_FETCH) &&
                        (((fifo_count + 2'(inflight)) < 2'd2) || pop);
    assign issue_last = (counter == LAST_ADDR);
    assign final_hs   = (state == S_DRAIN) && pop && out_last;

    // The address bus shows the new address in the issue cycle and otherwise holds the last one.
    assign BRAM1_addr = issue ? counter : addr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            counter       <= '0;
            addr_q        <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            inflight      <= issue;
            inflight_last <= issue && issue_last;
            done          <= final_hs;
            if (issue) begin
                addr_q  <= counter;
                counter <= counter + ADDR_WIDTH'(1);
            end
            // Busy covers the whole run including the done cycle.
            busy <= (state == S_IDLE) ? start : 1'b1;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_FETCH;
                        counter <= '0;
                    end
                end
                S_FETCH: begin
                    if (issue && issue_last) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (final_hs) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    layer1_skid_fifo #(
        .WIDTH(BUS_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data (BRAM_out),
        .push_last (inflight_last),
        .pop       (pop),
        .head_data (out_data),
        .head_last (out_last),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_layer1_fetch_ctrl.sv
// Directed bench for layer1_fetch_ctrl: full-length runs under several ready patterns,
// mid-run reset, ignored restarts, and a single-word configuration.
module tb_layer1_fetch_ctrl;
    import layer1_pkg::*;

    localparam int unsigned BUS_W = N_BRAM1_DEF * DATA_WIDTH_DEF;
    localparam int unsigned AW    = ADDR_WIDTH_DEF;
    localparam int          NW    = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, start, out_ready, start1, ready1;
    logic [AW-1:0]    addr, addr1;
    logic [BUS_W-1:0] bram, bram1, odata, odata1;
    logic             ovalid, olast, busy, done;
    logic             ovalid1, olast1, busy1, done1;

    int checks = 0;
    int errors = 0;

    layer1_fetch_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .BRAM1_addr(addr), .BRAM_out(bram),
        .out_data(odata), .out_valid(ovalid), .out_ready(out_ready), .out_last(olast),
        .busy(busy), .done(done)
    );

    layer1_fetch_ctrl #(.N_WORDS(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .BRAM1_addr(addr1), .BRAM_out(bram1),
        .out_data(odata1), .out_valid(ovalid1), .out_ready(ready1), .out_last(olast1),
        .busy(busy1), .done(done1)
    );

    // ROM contents: each lane a distinct affine function of the address
    function automatic logic [BUS_W-1:0] rom(input int a);
        logic [BUS_W-1:0] w;
        w = '0;
        for (int k = 0; k < int'(N_BRAM1_DEF); k++)
            w[k*DATA_WIDTH_DEF +: DATA_WIDTH_DEF] = 16'(a * 37 + k * 1000 + 5);
        return w;
    endfunction

    always @(posedge clk) begin
        bram  <= rom(int'(addr));
        bram1 <= rom(int'(addr1));
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // mode 0: ready high, 1: ready toggling, 2: ready low 50 cycles,
    // 3: reset after 500 words, 4: extra starts while busy
    task automatic run(input int mode, input int budget);
        int exp_addr, first_valid, done_cnt, done_cyc, rst_cyc;
        logic busy_c1, busy_at_done, busy_after, prev_stall, held_last;
        logic [BUS_W-1:0] held_data;
        exp_addr = 0; first_valid = -1; done_cnt = 0; done_cyc = -1; rst_cyc = -1;
        busy_c1 = 1'b0; busy_at_done = 1'b0; busy_after = 1'b1;
        prev_stall = 1'b0; held_last = 1'b0; held_data = '0;
        for (int c = 0; c < budget; c++) begin
            start = (c == 0) || (mode == 4 && (c == 10 || c == 600));
            rst   = (mode == 3 && rst_cyc < 0 && exp_addr == 500);
            if (rst) rst_cyc = c;
            case (mode)
                1:       out_ready = (c % 2 == 0);
                2:       out_ready = (c > 50);
                default: out_ready = !rst;
            endcase
            @(negedge clk);
            if (!rst) begin
                if (c == 1) busy_c1 = busy;
                if (ovalid && first_valid < 0) first_valid = c;
                if (done) begin
                    done_cnt++;
                    done_cyc = c;
                    busy_at_done = busy;
                end
                if (done_cyc >= 0 && c == done_cyc + 1) busy_after = busy;
                if (prev_stall) begin
                    chk("stall_valid", 64'(ovalid), 64'(1));
                    chk("stall_data", 64'(odata), 64'(held_data));
                    chk("stall_last", 64'(olast), 64'(held_last));
                end
                if (mode == 1 && exp_addr > 0)
                    chk("buffered_le3", 64'((int'(addr) + 1 - exp_addr) <= 3), 64'(1));
                if (ovalid && out_ready) begin
                    chk("word_data", 64'(odata), 64'(rom(exp_addr)));
                    chk("word_last", 64'(olast), 64'(exp_addr == NW - 1));
                    exp_addr++;
                end
                if (mode == 2 && (c == 3 || c == 50)) begin
                    chk("stall_addr_held", 64'(addr), 64'(1));
                    chk("stall_head_valid", 64'(ovalid), 64'(1));
                    chk("stall_head_data", 64'(odata), 64'(rom(0)));
                end
                if (mode == 3 && rst_cyc >= 0 && c == rst_cyc + 1) begin
                    chk("rst_addr", 64'(addr), 64'(0));
                    chk("rst_valid", 64'(ovalid), 64'(0));
                    chk("rst_last", 64'(olast), 64'(0));
                    chk("rst_data", 64'(odata), 64'(0));
                    chk("rst_busy", 64'(busy), 64'(0));
                    chk("rst_done", 64'(done), 64'(0));
                end
                prev_stall = ovalid && !out_ready;
                held_data  = odata;
                held_last  = olast;
            end else begin
                prev_stall = 1'b0;
            end
            @(posedge clk);
            #1;
            if (mode == 3) begin
                if (rst_cyc >= 0 && c >= rst_cyc + 20) break;
            end else if (done_cyc >= 0 && c >= done_cyc + 2) begin
                break;
            end
        end
        start = 1'b0;
        rst = 1'b0;
        out_ready = 1'b0;
        if (mode == 3) begin
            chk("rst_reached", 64'(rst_cyc >= 0), 64'(1));
            chk("rst_no_done", 64'(done_cnt), 64'(0));
        end else begin
            chk("word_count", 64'(exp_addr), 64'(NW));
            chk("done_count", 64'(done_cnt), 64'(1));
            chk("busy_cycle1", 64'(busy_c1), 64'(1));
            chk("busy_at_done", 64'(busy_at_done), 64'(1));
            chk("busy_after_done", 64'(busy_after), 64'(0));
            if (mode == 0 || mode == 4) chk("first_valid_cycle", 64'(first_valid), 64'(3));
            if (mode == 0) chk("done_cycle", 64'(done_cyc), 64'(1027));
        end
    endtask

    int n1_done;

    initial begin
        rst = 1'b1; start = 1'b0; out_ready = 1'b0; start1 = 1'b0; ready1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_addr", 64'(addr), 64'(0));
        chk("reset_valid", 64'(ovalid), 64'(0));
        chk("reset_last", 64'(olast), 64'(0));
        chk("reset_data", 64'(odata), 64'(0));
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_done", 64'(done), 64'(0));
        chk("reset1_valid", 64'(ovalid1), 64'(0));
        chk("reset1_busy", 64'(busy1), 64'(0));
        @(posedge clk);
        #1;

        run(0, 1200);
        run(1, 2300);
        run(2, 1200);
        run(3, 700);
        run(4, 1200);

        // single-word configuration, downstream accepts from cycle 5
        n1_done = 0;
        for (int c = 0; c < 12; c++) begin
            start1 = (c == 0);
            ready1 = (c >= 5);
            @(negedge clk);
            if (done1) n1_done++;
            if (c == 1) begin
                chk("n1_addr", 64'(addr1), 64'(0));
                chk("n1_busy_c1", 64'(busy1), 64'(1));
            end
            if (c == 2) chk("n1_valid_c2", 64'(ovalid1), 64'(0));
            if (c == 3) begin
                chk("n1_valid_c3", 64'(ovalid1), 64'(1));
                chk("n1_data", 64'(odata1), 64'(rom(0)));
                chk("n1_last", 64'(olast1), 64'(1));
            end
            if (c == 5) chk("n1_valid_hs", 64'(ovalid1), 64'(1));
            if (c == 6) begin
                chk("n1_done_pulse", 64'(done1), 64'(1));
                chk("n1_busy_done", 64'(busy1), 64'(1));
                chk("n1_valid_after", 64'(ovalid1), 64'(0));
            end
            if (c == 7) begin
                chk("n1_done_low", 64'(done1), 64'(0));
                chk("n1_busy_low", 64'(busy1), 64'(0));
            end
            @(posedge clk);
            #1;
        end
        start1 = 1'b0;
        ready1 = 1'b0;
        chk("n1_done_count", 64'(n1_done), 64'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
